// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing for the 1rw OpenRAM macro controller.
// Default geometry matches sram_*_1rw_freepdk45 (150b x 512).
package sram_ctrl_pkg;

  localparam int SRAM_DATA_WIDTH = 150;
  localparam int SRAM_ADDR_WIDTH = 9;
  localparam int SRAM_RSP_DEPTH  = 4;
  localparam int SRAM_CRED_W     = $clog2(SRAM_RSP_DEPTH + 1);

  typedef struct packed {
    logic                       we;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } sram_req_t;

  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Response FIFO for read data returning from the macro.
// Head data reads as zero while empty.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int W     = SRAM_DATA_WIDTH,
  parameter int DEPTH = SRAM_RSP_DEPTH,
  parameter int CW    = cred_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Initiator-side controller for a single-port 1rw OpenRAM macro.
// Registered macro pins, 2-stage read pipe, credit-protected responses.
module sram_1rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int RSP_DEPTH  = SRAM_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  busy
);

  localparam int CW = cred_w(RSP_DEPTH);

  logic          acc;
  logic          rd_s1;
  logic          rd_s2;
  logic          f_full;
  logic          f_empty;
  logic [CW-1:0] f_cnt;
  logic [CW:0]   used;
  logic          credit_ok;

  // Reads in the pipe already own a FIFO slot.
  assign used = (CW+1)'(f_cnt)
              + (CW+1)'(rd_s1)
              + (CW+1)'(rd_s2);

  assign credit_ok = !f_full && (used < (CW+1)'(RSP_DEPTH));
  assign req_ready = rst_n && (req_we || credit_ok);
  assign acc       = req_valid && req_ready;
  assign busy      = rd_s1 | rd_s2 | !f_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      rd_s1      <= 1'b0;
      rd_s2      <= 1'b0;
    end else begin
      sram_csb0 <= !acc;
      sram_web0 <= !(acc && req_we);
      if (acc) sram_addr0 <= req_addr;
      if (acc && req_we) sram_din0 <= req_wdata;
      rd_s1 <= acc && !req_we;
      rd_s2 <= rd_s1;
    end
  end

  sram_rsp_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (RSP_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_s2),
    .wdata (sram_dout0),
    .pop   (rsp_valid && rsp_ready),
    .rdata (rsp_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  assign rsp_valid = !f_empty;

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// Bench for sram_1rw_ctrl with a behavioural macro and a
// queue-based reference of outstanding reads and memory contents.
module tb_sram_1rw_ctrl;
  import sram_ctrl_pkg::*;

  localparam int DW = SRAM_DATA_WIDTH;
  localparam int AW = SRAM_ADDR_WIDTH;
  localparam int DEPTH = SRAM_RSP_DEPTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_csb0;
  logic          sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;
  logic          busy;

  sram_1rw_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural macro: command sampled one edge after the pins load.
  logic [DW-1:0] smem [1<<AW];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) smem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= smem[sram_addr0];
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } rsp_t;

  logic [DW-1:0] ref_mem [1<<AW];
  rsp_t          q[$];
  int            edge_n = 0;
  logic          prev_acc;
  logic          prev_we;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;
  int            checks = 0;
  int            errors = 0;
  int            n_rsp  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] r150();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic sram_req_t rq(input logic we, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d);
    return '{we: we, addr: a, wdata: d};
  endfunction

  // One clock: drive at negedge, check, advance the reference at posedge.
  task automatic step(input logic v, input sram_req_t r, input logic rr,
                      output logic acc);
    logic exp_rv;
    logic pop;
    req_valid = v;
    req_we    = r.we;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    rsp_ready = rr;
    #1;
    exp_rv = (q.size() > 0) && (q[0].due <= edge_n);
    chk("req_ready", req_ready, r.we || (q.size() < DEPTH));
    chk("busy", busy, q.size() > 0);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) chk("rsp_rdata", rsp_rdata, q[0].d);
    chk("csb0", sram_csb0, !prev_acc);
    chk("web0", sram_web0, !(prev_acc && prev_we));
    chk("addr0", sram_addr0, last_addr);
    chk("din0", sram_din0, last_din);
    chk("fifo_bound", dut.u_fifo.count <= DEPTH, 1'b1);
    acc = v && req_ready;
    pop = rsp_valid && rr && (q.size() > 0);
    @(posedge clk);
    edge_n++;
    if (pop) begin
      void'(q.pop_front());
      n_rsp++;
    end
    if (acc) begin
      last_addr = r.addr;
      if (r.we) begin
        ref_mem[r.addr] = r.wdata;
        last_din = r.wdata;
      end else begin
        q.push_back('{d: ref_mem[r.addr], due: edge_n + 2});
      end
    end
    prev_acc = acc;
    prev_we  = r.we;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    #1;
    chk("rst_csb0", sram_csb0, 1'b1);
    chk("rst_web0", sram_web0, 1'b1);
    chk("rst_addr0", sram_addr0, '0);
    chk("rst_din0", sram_din0, '0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    q.delete();
    prev_acc  = 1'b0;
    prev_we   = 1'b0;
    last_addr = '0;
    last_din  = '0;
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 40 && q.size() > 0; i++)
      step(1'b0, rq(1'b0, '0, '0), 1'b1, a);
    for (int i = 0; i < 3; i++)
      step(1'b0, rq(1'b0, '0, '0), 1'b1, a);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    logic          a;
    int            n;
    int            pend;
    int            base;
    logic [DW-1:0] wd;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset in the middle of a read: that read must never return.
    step(1'b1, rq(1'b0, 9'h010, '0), 1'b1, a);
    chk("mid_read_acc", a, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1'b0, rq(1'b0, '0, '0), 1'b1, a);
    chk("no_rsp_after_rst", n_rsp, 0);

    // Write then read the same address back to back.
    wd = {{142{1'b1}}, 8'hA5};
    step(1'b1, rq(1'b1, 9'h1A5, wd), 1'b1, a);
    step(1'b1, rq(1'b0, 9'h1A5, '0), 1'b1, a);
    drain();
    chk("wr_rd_rsp", n_rsp, 1);

    // Preload 0..15 with addr*3 and 16..31 with random data.
    for (int i = 0; i < 32; i++) begin
      wd = (i < 16) ? DW'(i * 3) : r150();
      step(1'b1, rq(1'b1, AW'(i), wd), 1'b1, a);
      chk("preload_acc", a, 1'b1);
    end

    // Streaming reads at full rate.
    base = n_rsp;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, rq(1'b0, AW'(i), '0), 1'b1, a);
      chk("stream_acc", a, 1'b1);
    end
    drain();
    chk("stream_cnt", n_rsp - base, 16);

    // Backpressure: only DEPTH reads fit while the consumer stalls.
    n = 0;
    pend = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rq(1'b0, AW'(pend), '0), 1'b0, a);
      if (a) begin
        n++;
        pend++;
      end
    end
    chk("bp_accepted", n, DEPTH);
    for (int i = 0; i < 30 && pend < 6; i++) begin
      step(1'b1, rq(1'b0, AW'(pend), '0), 1'b1, a);
      if (a) pend++;
    end
    chk("bp_all_acc", pend, 6);
    drain();

    // Writes are never stalled by a full response FIFO.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, rq(1'b0, AW'(16 + i), '0), 1'b0, a);
    for (int i = 0; i < 3; i++)
      step(1'b0, rq(1'b0, '0, '0), 1'b0, a);
    chk("fifo_full", dut.u_fifo.full, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rq(1'b1, AW'(9'h100 + i), r150()), 1'b0, a);
      chk("wr_full_acc", a, 1'b1);
    end
    drain();
    for (int i = 0; i < 3; i++)
      step(1'b1, rq(1'b0, AW'(9'h100 + i), '0), 1'b1, a);
    drain();

    // Idle quiescence.
    for (int i = 0; i < 20; i++)
      step(1'b0, rq(1'b0, AW'($urandom), r150()), 1'b1, a);

    // Random mix over the preloaded window.
    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0,
           rq(($urandom % 3) == 0, AW'($urandom % 32), r150()),
           ($urandom % 3) != 0, a);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
